// File: rtl/sweep_mode_ctrl.sv
// Drives the mode input of a free-running up/down counter so it sweeps BOTTOM..TOP..BOTTOM.
// Optional consistency checker on the counter value: define SWEEP_MODE_CTRL_CHECK_EN.
//
// state | meaning
// IDLE  | mode=0, counter free-runs upward, waiting for start
// ARM   | waiting for the counter to reach BOTTOM-1 so the sweep begins exactly at BOTTOM
// UP    | mode=0, counting up toward TOP
// DOWN  | mode=1, counting down toward BOTTOM
module sweep_mode_ctrl #(
    parameter int WIDTH  = 5,
    parameter int TOP    = 30,
    parameter int BOTTOM = 0,
    parameter int SWEEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] counter_in,
    output logic             mode,
    output logic             busy,
    output logic             reversal,
    output logic [3:0]       sweep_cnt,
    output logic             done
`ifdef SWEEP_MODE_CTRL_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_UP   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    // Turn decisions look one step ahead so mode flips on the edge that loads the turning value.
    localparam logic [WIDTH-1:0] BOT_C    = WIDTH'(BOTTOM);
    localparam logic [WIDTH-1:0] BOT_M1_C = WIDTH'(BOTTOM - 1);
    localparam logic [WIDTH-1:0] BOT_P1_C = WIDTH'(BOTTOM + 1);
    localparam logic [WIDTH-1:0] TOP_M1_C = WIDTH'(TOP - 1);
    localparam logic [3:0]       SWEEPS_C = 4'(SWEEPS);

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic       busy_q, busy_d;
    logic       rev_q, rev_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            rev_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            rev_q   <= rev_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rev_d   = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                mode_d = 1'b0;
                if (start && !stop) begin
                    cnt_d   = 4'd0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                mode_d = 1'b0;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (counter_in == BOT_M1_C) begin
                    state_d = S_UP;
                end
            end
            S_UP: begin
                if (stop) begin
                    mode_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (counter_in == TOP_M1_C) begin
                    mode_d  = 1'b1;
                    rev_d   = 1'b1;
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (stop) begin
                    mode_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (counter_in == BOT_P1_C) begin
                    mode_d = 1'b0;
                    rev_d  = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_d == SWEEPS_C) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_UP;
                    end
                end
            end
            default: begin
                mode_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign mode      = mode_q;
    assign busy      = busy_q;
    assign reversal  = rev_q;
    assign done      = done_q;
    assign sweep_cnt = cnt_q;

`ifdef SWEEP_MODE_CTRL_CHECK_EN
    // Shadow of what the counter should hold; only compared while sweeping.
    logic [WIDTH-1:0] exp_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ARM && state_d == S_UP) begin
                exp_q <= BOT_C;
            end else if (state_q == S_UP || state_q == S_DOWN) begin
                if (counter_in != exp_q) begin
                    err_q <= 1'b1;
                end
                exp_q <= mode_q ? (exp_q - 1'b1) : (exp_q + 1'b1);
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_sweep_mode_ctrl.sv
// Bench for sweep_mode_ctrl closed around a behavioural 5-bit up/down counter.
// Turn events go through a scoreboard queue; the err checker is exercised when SWEEP_MODE_CTRL_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_sweep_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       force_en = 1'b0;
    logic [4:0] force_val = 5'd0;
    logic [4:0] cnt;
    logic [4:0] cnt_in;
    logic       mode, busy, reversal, done;
    logic [3:0] sweep_cnt;
`ifdef SWEEP_MODE_CTRL_CHECK_EN
    logic       err;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [11:0] exp_ev[$];
    bit         in_sweep = 1'b0;

    always #5 clk = ~clk;

    // The counter under control: no enable, steps every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 5'd0;
        else        cnt <= mode ? cnt - 5'd1 : cnt + 5'd1;
    end

    assign cnt_in = force_en ? force_val : cnt;

    sweep_mode_ctrl #(
        .WIDTH (5),
        .TOP   (30),
        .BOTTOM(0),
        .SWEEPS(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .counter_in(cnt_in),
        .mode      (mode),
        .busy      (busy),
        .reversal  (reversal),
        .sweep_cnt (sweep_cnt),
        .done      (done)
`ifdef SWEEP_MODE_CTRL_CHECK_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Event record: {counter, mode, sweep_cnt, done, reversal}
    function automatic logic [11:0] ev(input logic [4:0] c, input logic m, input logic [3:0] s, input logic d);
        return {c, m, s, d, 1'b1};
    endfunction

    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst_n) begin
            in_sweep = 1'b0;
        end else begin
            if (reversal || done) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=%0h required=none", {cnt, mode, sweep_cnt, done, reversal});
                end else begin
                    e = exp_ev.pop_front();
                    check("turn_event", {20'd0, cnt, mode, sweep_cnt, done, reversal}, {20'd0, e});
                end
            end
            if (!busy) in_sweep = 1'b0;
            else if (cnt == 5'd0) in_sweep = 1'b1;
            if (in_sweep) check("no_31_while_sweeping", cnt == 5'd31, 0);
        end
    end

    task automatic start_session();
        for (int i = 0; i < 64 && cnt != 5'd5; i++) @(negedge clk);
        check("start_align", cnt, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy_in_reset", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_busy", busy, 0);
        check("rst_sweep_cnt", sweep_cnt, 0);
        check("rst_done", done, 0);
        check("rst_reversal", reversal, 0);
        check("idle_counts_up", cnt, 1);

        // Full session with SWEEPS=2
        start_session();
        check("arm_busy", busy, 1);
        check("arm_sweep_cnt_clear", sweep_cnt, 0);
        exp_ev.push_back(ev(5'd30, 1'b1, 4'd0, 1'b0));
        exp_ev.push_back(ev(5'd0,  1'b0, 4'd1, 1'b0));
        exp_ev.push_back(ev(5'd30, 1'b1, 4'd1, 1'b0));
        exp_ev.push_back(ev(5'd0,  1'b0, 4'd2, 1'b1));
        for (int i = 0; i < 100 && !(in_sweep && cnt == 5'd29 && mode == 1'b0); i++) @(negedge clk);
        check("wait_up29", in_sweep && cnt == 5'd29 && mode == 1'b0, 1);
        @(negedge clk);
        check("turn_mode", mode, 1);
        check("turn_cnt_top", cnt, 30);
        @(negedge clk);
        check("turn_cnt_after", cnt, 29);
        for (int i = 0; i < 100 && !(sweep_cnt == 4'd1 && cnt == 5'd10 && mode == 1'b0); i++) @(negedge clk);
        check("wait_second_up", sweep_cnt == 4'd1 && cnt == 5'd10 && mode == 1'b0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy_ignored_cnt", sweep_cnt, 1);
        check("start_busy_ignored_busy", busy, 1);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("done_pulse", done, 1);
        check("done_cnt_zero", cnt, 0);
        check("done_sweep_cnt", sweep_cnt, 2);
        check("done_mode", mode, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("sweep_cnt_hold", sweep_cnt, 2);
        check("idle_after_done", cnt, 1);
        check("queue_drained_run", exp_ev.size(), 0);
`ifdef SWEEP_MODE_CTRL_CHECK_EN
        check("err_clean_run", err, 0);
`endif

        // stop coinciding with the TOP turn point
        start_session();
        exp_ev.push_back(ev(5'd30, 1'b1, 4'd0, 1'b0));
        exp_ev.push_back(ev(5'd0,  1'b0, 4'd1, 1'b0));
        for (int i = 0; i < 200 && !(busy && sweep_cnt == 4'd1 && cnt == 5'd29 && mode == 1'b0); i++) @(negedge clk);
        check("wait_stop_point", busy && sweep_cnt == 4'd1 && cnt == 5'd29 && mode == 1'b0, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_mode", mode, 0);
        check("stop_cnt", cnt, 30);
        check("stop_busy", busy, 0);
        check("stop_no_reversal", reversal, 0);
        @(negedge clk);
        check("stop_cnt_wrap31", cnt, 31);
        check("stop_sweep_cnt_hold", sweep_cnt, 1);
        check("stop_no_done", done, 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle_busy", busy, 0);
        check("start_stop_idle_cnt", sweep_cnt, 1);
        @(negedge clk);
        check("start_stop_idle_busy2", busy, 0);

        // Asynchronous reset in the middle of a DOWN sweep
        start_session();
        exp_ev.push_back(ev(5'd30, 1'b1, 4'd0, 1'b0));
        exp_ev.push_back(ev(5'd0,  1'b0, 4'd1, 1'b0));
        exp_ev.push_back(ev(5'd30, 1'b1, 4'd1, 1'b0));
        for (int i = 0; i < 200 && !(sweep_cnt == 4'd1 && mode == 1'b1 && cnt == 5'd15); i++) @(negedge clk);
        check("wait_mid_down", sweep_cnt == 4'd1 && mode == 1'b1 && cnt == 5'd15, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mode", mode, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sweep_cnt", sweep_cnt, 0);
        check("async_rst_done", done, 0);
        check("async_rst_reversal", reversal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("queue_drained_reset", exp_ev.size(), 0);
        @(negedge clk);

`ifdef SWEEP_MODE_CTRL_CHECK_EN
        // Corrupt one counter sample during UP
        check("err_after_reset", err, 0);
        start_session();
        for (int i = 0; i < 100 && !(in_sweep && cnt == 5'd12 && mode == 1'b0); i++) @(negedge clk);
        check("wait_up12", in_sweep && cnt == 5'd12 && mode == 1'b0, 1);
        check("err_before_fault", err, 0);
        force_val = 5'd17;
        force_en  = 1'b1;
        @(negedge clk);
        force_en  = 1'b0;
        check("err_set", err, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("err_sticky_stop", err, 1);
        check("err_stop_busy", busy, 0);
        start_session();
        check("err_restart_busy", busy, 1);
        check("err_sticky_restart", err, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
